// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared definitions for the grayscale engine and its host:
//            size field geometry, gray byte lane, error bit indices and the
//            host sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int WD_SIZE_MAX  = 10;   // bits needed for the size in 1k units
  localparam int WD_SIZE_UNIT = 10;   // log2 of pixels per size unit
  localparam int WD_RGB_888   = 8;    // one colour channel / gray byte
  localparam int WD_PIX       = WD_SIZE_MAX + WD_SIZE_UNIT;

  localparam int SIZE_LIMIT   = 512;  // largest frame in 1k-pixel units

  // Gray value lane inside a processed BRAM word
  localparam int GRAY_MSB     = 31;
  localparam int GRAY_LSB     = 24;

  // Local error bit indices, shared with the gray engine
  localparam int ERR_IDX_SIZE    = 0;
  localparam int ERR_IDX_TIMEOUT = 1;
  localparam int NB_ERR_LOCAL    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_LATCH = 3'd4,
    ST_SEND  = 3'd5,
    ST_DONE  = 3'd6
  } gray_state_e;

  // Index of the final pixel of a frame of 'units' 1k-pixel blocks
  function automatic logic [WD_PIX-1:0] last_pix(input logic [WD_SIZE_MAX-1:0] units);
    logic [WD_SIZE_MAX-1:0] blk;
    blk = units - WD_SIZE_MAX'(1);
    return {blk, {WD_SIZE_UNIT{1'b1}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_bram_rd.sv
`default_nettype none
// ============================================================================
// Module   : gray_bram_rd
// Purpose  : Single-word BRAM read sequencer. A request pulse drives the
//            address with enable for one cycle, then waits NB_READ_STEP
//            cycles and flags the cycle in which read data is valid.
// Revision : 1.0 - initial release
// ============================================================================
module gray_bram_rd
  import gray_pkg::*;
#(
  parameter int WD_BRAM_DAT  = 32,
  parameter int NB_READ_STEP = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_req,
  input  logic [WD_BRAM_DAT-1:0] rd_addr,
  output logic                   bram_en,
  output logic [WD_BRAM_DAT-1:0] bram_addr,
  output logic                   lat_done
);

  localparam int WD_CNT = $clog2(NB_READ_STEP + 1);
  localparam logic [WD_CNT-1:0] CNT_LAST = WD_CNT'(NB_READ_STEP - 1);

  logic                   en_q, en_d;
  logic [WD_BRAM_DAT-1:0] addr_q, addr_d;
  logic                   wait_q, wait_d;
  logic [WD_CNT-1:0]      cnt_q, cnt_d;

  // Enable lasts exactly the request cycle; latency count starts right after
  always_comb begin
    en_d   = rd_req;
    addr_d = rd_req ? rd_addr : addr_q;
    wait_d = wait_q;
    cnt_d  = cnt_q;
    if (en_q) begin
      wait_d = 1'b1;
      cnt_d  = '0;
    end else if (wait_q) begin
      if (cnt_q == CNT_LAST) begin
        wait_d = 1'b0;
      end else begin
        cnt_d = cnt_q + WD_CNT'(1);
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      wait_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      wait_q <= wait_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bram_en   = en_q;
  assign bram_addr = addr_q;
  assign lat_done  = wait_q && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/gray_host.sv
`default_nettype none
// ============================================================================
// Module   : gray_host
// Purpose  : Shake-bus master and result reader for the grayscale engine.
//            Validates the frame size, requests processing, waits for the
//            completion pulse, then streams the gray byte of every pixel
//            out of the shared BRAM as a ready/valid byte stream.
// Revision : 1.0 - initial release
// ============================================================================
module gray_host
  import gray_pkg::*;
#(
  parameter int WD_SHK_SYNC  = 16,
  parameter int WD_SHK_DLAY  = 15,
  parameter int WD_BRAM_DAT  = 32,
  parameter int WD_BRAM_WEN  = 4,
  parameter int WD_ERR_INFO  = 4,
  parameter int NB_READ_STEP = 3,
  parameter int WD_TIMEOUT   = 24
) (
  input  logic                   s_sys_a_clock,
  input  logic                   s_sys_a_reset,
  input  logic                   s_cmd_gray_start,
  input  logic [WD_SHK_SYNC-1:0] s_cmd_gray_size,
  output logic                   s_cmd_gray_busy,
  output logic                   m_shk_gray_wvalid,
  output logic [WD_SHK_SYNC-1:0] m_shk_gray_smosi,
  output logic [WD_SHK_DLAY-1:0] m_shk_gray_dmosi,
  input  logic                   m_shk_gray_wready,
  input  logic [WD_SHK_SYNC-1:0] m_shk_gray_smiso,
  input  logic [WD_SHK_DLAY-1:0] m_shk_gray_dmiso,
  output logic [WD_BRAM_DAT-1:0] m_bram_gray_addr,
  output logic                   m_bram_gray_clk,
  output logic [WD_BRAM_DAT-1:0] m_bram_gray_din,
  input  logic [WD_BRAM_DAT-1:0] m_bram_gray_dout,
  output logic                   m_bram_gray_en,
  output logic                   m_bram_gray_rst,
  output logic [WD_BRAM_WEN-1:0] m_bram_gray_we,
  output logic                   m_axis_gray_tvalid,
  output logic [WD_RGB_888-1:0]  m_axis_gray_tdata,
  output logic                   m_axis_gray_tlast,
  input  logic                   m_axis_gray_tready,
  input  logic [WD_ERR_INFO-1:0] s_err_gray_info1,
  output logic [WD_ERR_INFO-1:0] m_err_gray_info1
);

  gray_state_e             state_q, state_d;
  logic [WD_SHK_SYNC-1:0]  size_q, size_d;
  logic [WD_PIX-1:0]       pix_q, pix_d;
  logic [WD_TIMEOUT-1:0]   tmo_q, tmo_d;
  logic [NB_ERR_LOCAL-1:0] err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    wvalid_q, wvalid_d;
  logic [WD_SHK_SYNC-1:0]  smosi_q, smosi_d;
  logic                    tvalid_q, tvalid_d;
  logic [WD_RGB_888-1:0]   tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;

  logic                    rd_req;
  logic [WD_PIX-1:0]       rd_pix;
  logic                    lat_done;
  logic                    size_bad;
  logic [WD_PIX-1:0]       pix_end;

  assign size_bad = (size_q == '0) || (size_q > WD_SHK_SYNC'(SIZE_LIMIT));
  assign pix_end  = last_pix(size_q[WD_SIZE_MAX-1:0]);

  // Frame sequencer: size check, shake request, then one read per pixel
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    pix_d    = pix_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    rd_req   = 1'b0;
    rd_pix   = pix_q;
    case (state_q)
      ST_IDLE: begin
        if (s_cmd_gray_start) begin
          state_d = ST_CHECK;
          size_d  = s_cmd_gray_size;
          err_d   = '0;
        end
      end
      ST_CHECK: begin
        pix_d = '0;
        tmo_d = '0;
        if (size_bad) begin
          state_d             = ST_DONE;
          err_d[ERR_IDX_SIZE] = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A completion pulse only counts once the request is visible
        if (wvalid_q && m_shk_gray_wready) begin
          state_d = ST_ISSUE;
          rd_req  = 1'b1;
        end else if (&tmo_q) begin
          state_d                = ST_DONE;
          err_d[ERR_IDX_TIMEOUT] = 1'b1;
        end else begin
          tmo_d = tmo_q + WD_TIMEOUT'(1);
        end
      end
      ST_ISSUE: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (lat_done) begin
          state_d  = ST_SEND;
          tvalid_d = 1'b1;
          tdata_d  = m_bram_gray_dout[GRAY_MSB:GRAY_LSB];
          tlast_d  = (pix_q == pix_end);
        end
      end
      ST_SEND: begin
        if (m_axis_gray_tready) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            state_d = ST_DONE;
          end else begin
            pix_d   = pix_q + WD_PIX'(1);
            rd_pix  = pix_q + WD_PIX'(1);
            rd_req  = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d   = (state_d != ST_IDLE);
    // Request drops the cycle after the pulse or timeout is seen
    wvalid_d = (state_q == ST_REQ) && (state_d == ST_REQ);
    smosi_d  = (state_d == ST_REQ) ? size_q : '0;
  end

  // Sequencer and registered output flops
  always_ff @(posedge s_sys_a_clock) begin
    if (s_sys_a_reset) begin
      state_q  <= ST_IDLE;
      size_q   <= '0;
      pix_q    <= '0;
      tmo_q    <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      wvalid_q <= 1'b0;
      smosi_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      pix_q    <= pix_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      wvalid_q <= wvalid_d;
      smosi_q  <= smosi_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  gray_bram_rd #(
    .WD_BRAM_DAT  (WD_BRAM_DAT),
    .NB_READ_STEP (NB_READ_STEP)
  ) u_bram_rd (
    .clk       (s_sys_a_clock),
    .rst       (s_sys_a_reset),
    .rd_req    (rd_req),
    .rd_addr   (WD_BRAM_DAT'(rd_pix)),
    .bram_en   (m_bram_gray_en),
    .bram_addr (m_bram_gray_addr),
    .lat_done  (lat_done)
  );

  assign s_cmd_gray_busy    = busy_q;
  assign m_shk_gray_wvalid  = wvalid_q;
  assign m_shk_gray_smosi   = smosi_q;
  assign m_shk_gray_dmosi   = '0;
  assign m_bram_gray_clk    = s_sys_a_clock;
  assign m_bram_gray_din    = '0;
  assign m_bram_gray_rst    = 1'b0;
  assign m_bram_gray_we     = '0;
  assign m_axis_gray_tvalid = tvalid_q;
  assign m_axis_gray_tdata  = tdata_q;
  assign m_axis_gray_tlast  = tlast_q;
  assign m_err_gray_info1   = s_err_gray_info1 | WD_ERR_INFO'(err_q);

  // Engine response fields and the non-gray lanes of the word carry nothing here
  logic unused_ok;
  assign unused_ok = ^{m_shk_gray_smiso, m_shk_gray_dmiso, m_bram_gray_dout[GRAY_LSB-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_gray_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_host
// Purpose  : Self-checking bench for gray_host: engine and BRAM models, a
//            randomised sink, and a frame-level scoreboard that predicts
//            each streamed byte from its pixel index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_host;

  localparam int WD_SHK_SYNC  = 16;
  localparam int WD_SHK_DLAY  = 15;
  localparam int WD_BRAM_DAT  = 32;
  localparam int WD_BRAM_WEN  = 4;
  localparam int WD_ERR_INFO  = 4;
  localparam int NB_READ_STEP = 3;
  localparam int WD_TIMEOUT   = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [WD_SHK_SYNC-1:0] size_in = '0;
  logic                   busy;
  logic                   wvalid;
  logic [WD_SHK_SYNC-1:0] smosi;
  logic [WD_SHK_DLAY-1:0] dmosi;
  logic                   wready = 1'b0;
  logic [WD_BRAM_DAT-1:0] bram_addr;
  logic                   bram_clk;
  logic [WD_BRAM_DAT-1:0] bram_din;
  logic [WD_BRAM_DAT-1:0] bram_dout;
  logic                   bram_en;
  logic                   bram_rst;
  logic [WD_BRAM_WEN-1:0] bram_we;
  logic                   tvalid;
  logic [7:0]             tdata;
  logic                   tlast;
  logic                   tready = 1'b0;
  logic [WD_ERR_INFO-1:0] s_err = '0;
  logic [WD_ERR_INFO-1:0] err;

  always #5 clk = ~clk;

  gray_host #(
    .WD_SHK_SYNC  (WD_SHK_SYNC),
    .WD_SHK_DLAY  (WD_SHK_DLAY),
    .WD_BRAM_DAT  (WD_BRAM_DAT),
    .WD_BRAM_WEN  (WD_BRAM_WEN),
    .WD_ERR_INFO  (WD_ERR_INFO),
    .NB_READ_STEP (NB_READ_STEP),
    .WD_TIMEOUT   (WD_TIMEOUT)
  ) dut (
    .s_sys_a_clock      (clk),
    .s_sys_a_reset      (rst),
    .s_cmd_gray_start   (start),
    .s_cmd_gray_size    (size_in),
    .s_cmd_gray_busy    (busy),
    .m_shk_gray_wvalid  (wvalid),
    .m_shk_gray_smosi   (smosi),
    .m_shk_gray_dmosi   (dmosi),
    .m_shk_gray_wready  (wready),
    .m_shk_gray_smiso   ('0),
    .m_shk_gray_dmiso   ('0),
    .m_bram_gray_addr   (bram_addr),
    .m_bram_gray_clk    (bram_clk),
    .m_bram_gray_din    (bram_din),
    .m_bram_gray_dout   (bram_dout),
    .m_bram_gray_en     (bram_en),
    .m_bram_gray_rst    (bram_rst),
    .m_bram_gray_we     (bram_we),
    .m_axis_gray_tvalid (tvalid),
    .m_axis_gray_tdata  (tdata),
    .m_axis_gray_tlast  (tlast),
    .m_axis_gray_tready (tready),
    .s_err_gray_info1   (s_err),
    .m_err_gray_info1   (err)
  );

  // ---------------- shared bench state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          tready_mode = 0;   // 0 always, 1 pattern 1,0,0,1, 2 random, 3 never
  bit          eng_en   = 1'b1;
  logic [7:0]  key      = 8'h00;
  bit          frame_act = 1'b0;
  int          frame_pix = 0;
  int          beat_idx  = 0;
  int          lasts     = 0;
  int          last_hs_cyc = 0;
  int          wv_cnt    = 0;
  logic [7:0]  last_tdata = 8'h00;
  logic [WD_SHK_SYNC-1:0] exp_size = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Byte the engine leaves in the gray lane of word 'a'
  function automatic logic [7:0] exp_byte(input logic [31:0] a, input logic [7:0] k);
    logic [7:0] hi;
    hi = a[15:8];
    return a[7:0] + k * hi;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: word read at an enabled edge appears NB_READ_STEP edges later
  logic [31:0] pipe [NB_READ_STEP];
  always @(posedge clk) begin
    pipe[0] <= bram_en ? {exp_byte(bram_addr, key), 24'($urandom)} : $urandom;
    for (int i = 1; i < NB_READ_STEP; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_dout = pipe[NB_READ_STEP-1];

  // Engine model: single-cycle completion pulse a random time after the request
  int eng_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      wready  <= 1'b0;
      eng_cnt <= 0;
    end else if (wready) begin
      wready <= 1'b0;
    end else if (!wvalid) begin
      eng_cnt <= $urandom_range(0, 4);
    end else if (eng_en) begin
      if (eng_cnt == 0) wready <= 1'b1;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  // Sink ready generator
  int pat = 0;
  always @(posedge clk) begin
    pat <= pat + 1;
    case (tready_mode)
      0:       tready <= 1'b1;
      1:       tready <= (pat % 4 == 0) || (pat % 4 == 3);
      2:       tready <= 1'($urandom_range(0, 1));
      default: tready <= 1'b0;
    endcase
  end

  // Compare process: stream scoreboard and handshake rules, every cycle
  initial begin
    bit         prev_stall = 1'b0;
    bit         prev_wack  = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_wack  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", tvalid, 1);
          check("stall_data", tdata, prev_data);
          check("stall_last", tlast, prev_last);
        end
        if (tvalid && tready) begin
          check("beat_in_frame", frame_act, 1);
          if (frame_act) begin
            check("tdata", tdata, exp_byte(beat_idx, key));
            check("tlast", tlast, beat_idx == frame_pix - 1);
            if (tready_mode == 0 && beat_idx > 0)
              check("pixel_period", cyc - last_hs_cyc, 5);
            last_hs_cyc = cyc;
            last_tdata  = tdata;
            if (tlast) lasts++;
            beat_idx++;
            if (beat_idx == frame_pix) frame_act = 1'b0;
          end
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
        if (prev_wack) check("wvalid_drop", wvalid, 0);
        prev_wack = wvalid && wready;
        if (wvalid) begin
          wv_cnt++;
          check("smosi", smosi, exp_size);
        end
        if (bram_en) check("bram_wr_quiet", {bram_we, bram_din[0], bram_rst}, 0);
      end
    end
  end

  // ---------------- directed sequence helpers ----------------
  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_smosi", smosi, 0);
    check("rst_dmosi", dmosi, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_en", bram_en, 0);
    check("rst_din", bram_din, 0);
    check("rst_brst", bram_rst, 0);
    check("rst_we", bram_we, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_err", err, s_err);
    check("rst_bram_clk", bram_clk, clk);
  endtask

  task automatic start_cmd(input int sz);
    @(posedge clk);
    #1 start = 1'b1;
    size_in = WD_SHK_SYNC'(sz);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Arm the model for a frame and issue the start; returns just after edge 0
  task automatic begin_frame(input int sz, input bit expect_beats);
    exp_size  = WD_SHK_SYNC'(sz);
    frame_pix = sz * 1024;
    beat_idx  = 0;
    lasts     = 0;
    wv_cnt    = 0;
    frame_act = expect_beats;
    start_cmd(sz);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("err_cleared", err, s_err);
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_falls", busy, 0);
  endtask

  task automatic end_frame_checks();
    check("beat_count", beat_idx, frame_pix);
    check("tlast_count", lasts, 1);
    check("busy_after_last", cyc - last_hs_cyc, 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    s_err = 4'b1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    check("err_passthrough", err, 4'b1000);
    @(posedge clk);
    #1 rst = 1'b0;
    s_err = '0;

    // Size 1, plain data, always-ready sink; start during the frame is ignored
    key = 8'h00;
    tready_mode = 0;
    begin_frame(1, 1'b1);
    @(negedge clk);
    check("wvalid_edge1", wvalid, 0);
    @(negedge clk);
    check("wvalid_edge2", wvalid, 1);
    n = 0;
    while (beat_idx < 10 && n < 200) begin @(negedge clk); n++; end
    check("reach_beat10", beat_idx >= 10, 1);
    start_cmd(0);
    wait_idle(8000, n);
    end_frame_checks();
    check("last_byte_ff", last_tdata, 8'hFF);
    check("no_err_after_ignored_start", err, 4'b0000);

    // Rejected sizes
    begin_frame(0, 1'b0);
    wait_idle(2, n);
    check("size0_err", err, 4'b0001);
    check("size0_no_wvalid", wv_cnt, 0);
    begin_frame(513, 1'b0);
    wait_idle(2, n);
    check("size513_err", err, 4'b0001);
    check("size513_no_wvalid", wv_cnt, 0);

    // Size 1 with a 1,0,0,1 ready pattern
    key = 8'($urandom) | 8'h01;
    tready_mode = 1;
    begin_frame(1, 1'b1);
    wait_idle(12000, n);
    end_frame_checks();

    // Size 2 with a random ready
    key = 8'($urandom) | 8'h01;
    tready_mode = 2;
    begin_frame(2, 1'b1);
    wait_idle(30000, n);
    end_frame_checks();

    // Size 512 accepted; abandon it by reset while a beat is stalled
    key = 8'($urandom);
    tready_mode = 0;
    begin_frame(512, 1'b1);
    n = 0;
    while (beat_idx < 6 && n < 400) begin @(negedge clk); n++; end
    check("big_reach_beat6", beat_idx >= 6, 1);
    tready_mode = 3;
    repeat (2) @(negedge clk);
    n = 0;
    while (!tvalid && n < 20) begin @(negedge clk); n++; end
    check("big_stalled", tvalid, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    frame_act = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;
    tready_mode = 0;

    // Normal frame after the abandoned one
    key = 8'($urandom);
    begin_frame(1, 1'b1);
    wait_idle(8000, n);
    end_frame_checks();

    // Engine never answers: request times out
    eng_en = 1'b0;
    begin_frame(3, 1'b0);
    wait_idle(400, n);
    check("timeout_wvalid_cycles", wv_cnt, 255);
    check("timeout_err", err, 4'b0010);
    check("timeout_wvalid_low", wvalid, 0);
    eng_en = 1'b1;

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
